// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with branch/jump resolution, registered fetch
// redirect, wrong-path squash after a redirect and misaligned-target detect.
module ex_mem_stage #(
  parameter int WIDTH       = 32,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic [WIDTH-1:0] ex_alu_out,
  input  logic             ex_zero,
  input  logic [WIDTH-1:0] ex_pc,
  input  logic [WIDTH-1:0] ex_imm,
  input  logic [WIDTH-1:0] ex_rs2_data,
  input  logic [4:0]       ex_rd,
  input  logic [2:0]       ex_funct3,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic             ex_mem_write,
  input  logic             ex_is_branch,
  input  logic             ex_is_jal,
  input  logic             ex_is_jalr,
  input  logic             mem_ready,
  output logic             mem_valid,
  output logic [WIDTH-1:0] mem_alu_out,
  output logic [WIDTH-1:0] mem_rs2_data,
  output logic [4:0]       mem_rd,
  output logic [2:0]       mem_funct3,
  output logic             mem_reg_write,
  output logic             mem_mem_read,
  output logic             mem_mem_write,
  output logic             redirect_valid,
  output logic [WIDTH-1:0] redirect_pc,
  output logic             misalign_exc
);

  typedef enum logic {RUN, KILL} state_t;

  state_t           state;
  logic [1:0]       kill_cnt;
  logic             accept, squash, is_jump, taken, misal, redir;
  logic [WIDTH-1:0] target, link;
  logic             rw_q, mr_q, mw_q;

  localparam logic [WIDTH-1:0] CLR_LSB = {{(WIDTH-1){1'b1}}, 1'b0};

  assign ex_ready = !mem_valid | mem_ready;
  assign accept   = ex_valid & ex_ready;
  // Anything accepted while killing is wrong-path and never reaches MEM.
  assign squash   = accept & (state == KILL);

  assign is_jump = ex_is_jal | ex_is_jalr;
  assign taken   = (ex_is_branch & ex_zero) | is_jump;
  assign target  = ex_is_jalr ? (ex_alu_out & CLR_LSB) : ex_pc + ex_imm;
  assign link    = ex_pc + WIDTH'(4);
  // Only bit 1 matters: bit 0 is already clear for JALR, and branch/JAL
  // immediates are even by encoding.
  assign misal   = taken & target[1];
  assign redir   = taken & ~target[1];

  // Control bits only mean something while the slot holds a live instruction.
  assign mem_reg_write = rw_q & mem_valid;
  assign mem_mem_read  = mr_q & mem_valid;
  assign mem_mem_write = mw_q & mem_valid;

  // Squash FSM: arm on an accepted redirect, count down on each squashed accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      kill_cnt <= '0;
    end else if (accept) begin
      if (state == KILL) begin
        kill_cnt <= kill_cnt - 2'd1;
        if (kill_cnt == 2'd1) state <= RUN;
      end else if (redir) begin
        state    <= KILL;
        kill_cnt <= 2'(FLUSH_DEPTH);
      end
    end
  end

  // Redirect and exception pulses, raised for one cycle after a live accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      misalign_exc   <= 1'b0;
    end else begin
      redirect_valid <= accept & ~squash & redir;
      misalign_exc   <= accept & ~squash & misal;
      if (accept & ~squash & redir) redirect_pc <= target;
    end
  end

  // MEM slot: load on a live accept, drain on handoff, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_valid    <= 1'b0;
      mem_alu_out  <= '0;
      mem_rs2_data <= '0;
      mem_rd       <= '0;
      mem_funct3   <= '0;
      rw_q         <= 1'b0;
      mr_q         <= 1'b0;
      mw_q         <= 1'b0;
    end else if (accept & ~squash) begin
      mem_valid    <= 1'b1;
      mem_alu_out  <= is_jump ? link : ex_alu_out;
      mem_rs2_data <= ex_rs2_data;
      mem_rd       <= ex_rd;
      mem_funct3   <= ex_funct3;
      // A misaligned target turns the instruction into a harmless bubble.
      rw_q         <= ex_reg_write & ~misal;
      mr_q         <= ex_mem_read  & ~misal;
      mw_q         <= ex_mem_write & ~misal;
    end else if (mem_ready) begin
      mem_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: table of vectors with hand-written expectations,
// a scoreboard queue for MEM results, plus reset/stall sequences.
module tb_ex_mem_stage;

  logic        clk, rst, ex_valid, ex_ready, ex_zero;
  logic [31:0] ex_alu_out, ex_pc, ex_imm, ex_rs2_data;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_funct3;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;
  logic        ex_is_branch, ex_is_jal, ex_is_jalr, mem_ready;
  logic        mem_valid, mem_reg_write, mem_mem_read, mem_mem_write;
  logic [31:0] mem_alu_out, mem_rs2_data, redirect_pc;
  logic [4:0]  mem_rd;
  logic [2:0]  mem_funct3;
  logic        redirect_valid, misalign_exc;

  ex_mem_stage #(.WIDTH(32), .FLUSH_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_out(ex_alu_out), .ex_zero(ex_zero), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_is_branch(ex_is_branch),
    .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr), .mem_ready(mem_ready),
    .mem_valid(mem_valid), .mem_alu_out(mem_alu_out),
    .mem_rs2_data(mem_rs2_data), .mem_rd(mem_rd), .mem_funct3(mem_funct3),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .misalign_exc(misalign_exc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ctl = {valid, squash_expected, zero, br, jal, jalr, rw, mr, mw}
  typedef struct {
    logic [8:0]  ctl;
    logic [31:0] alu, pc, imm, rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [31:0] e_alu;
    logic [2:0]  e_wr;
    logic        e_mis, e_redir;
    logic [31:0] e_rpc;
  } vec_t;

  typedef struct {
    logic [31:0] alu, rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [2:0]  wr;
  } exp_t;

  vec_t tbl[29];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [8:0] ctl, input logic [31:0] alu,
      input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs2,
      input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] e_alu,
      input logic [2:0] e_wr, input logic e_mis, input logic e_redir,
      input logic [31:0] e_rpc);
    vec_t v;
    v.ctl = ctl; v.alu = alu; v.pc = pc; v.imm = imm; v.rs2 = rs2;
    v.rd = rd; v.f3 = f3; v.e_alu = e_alu; v.e_wr = e_wr;
    v.e_mis = e_mis; v.e_redir = e_redir; v.e_rpc = e_rpc;
    return v;
  endfunction

  task automatic drive(input vec_t v, input logic mrdy);
    {ex_valid, ex_zero, ex_is_branch, ex_is_jal, ex_is_jalr,
     ex_reg_write, ex_mem_read, ex_mem_write} = {v.ctl[8], v.ctl[6:0]};
    ex_alu_out = v.alu; ex_pc = v.pc; ex_imm = v.imm; ex_rs2_data = v.rs2;
    ex_rd = v.rd; ex_funct3 = v.f3; mem_ready = mrdy;
  endtask

  task automatic check_mem(input string tag);
    exp_t e;
    chk({tag, ".mem_valid"}, {31'd0, mem_valid}, 32'd1);
    if (sb.size() == 0) begin
      chk({tag, ".scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, ".alu_out"}, mem_alu_out, e.alu);
      chk({tag, ".rs2"}, mem_rs2_data, e.rs2);
      chk({tag, ".rd"}, {27'd0, mem_rd}, {27'd0, e.rd});
      chk({tag, ".funct3"}, {29'd0, mem_funct3}, {29'd0, e.f3});
      chk({tag, ".wr"}, {29'd0, mem_reg_write, mem_mem_read, mem_mem_write},
          {29'd0, e.wr});
    end
  endtask

  function automatic exp_t mkexp(input vec_t v);
    exp_t e;
    e.alu = v.e_alu; e.rs2 = v.rs2; e.rd = v.rd; e.f3 = v.f3; e.wr = v.e_wr;
    return e;
  endfunction

  vec_t idle, v;

  initial begin
    idle = mk(9'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 3'd0, 32'h0, 3'b0, 1'b0, 1'b0, 32'h0);
    tbl[0]  = mk(9'b1_0_0_000_100, 32'h10, 32'h0, 32'h0, 32'h0, 5'd5, 3'd0, 32'h10, 3'b100, 1'b0, 1'b0, 32'h0);
    tbl[1]  = mk(9'b1_0_0_000_001, 32'h2000, 32'h0, 32'h0, 32'hDEADBEEF, 5'd0, 3'd2, 32'h2000, 3'b001, 1'b0, 1'b0, 32'h0);
    tbl[2]  = mk(9'b1_0_0_000_110, 32'h3004, 32'h0, 32'h0, 32'h0, 5'd7, 3'd2, 32'h3004, 3'b110, 1'b0, 1'b0, 32'h0);
    tbl[3]  = mk(9'b1_0_1_100_000, 32'h0, 32'h100, 32'h20, 32'h0, 5'd0, 3'd0, 32'h0, 3'b000, 1'b0, 1'b1, 32'h120);
    tbl[4]  = mk(9'b1_1_0_000_100, 32'h55, 32'h0, 32'h0, 32'h0, 5'd3, 3'd0, 32'h0, 3'b0, 1'b0, 1'b0, 32'h0);
    tbl[5]  = mk(9'b1_1_1_100_000, 32'h0, 32'h200, 32'h40, 32'h0, 5'd0, 3'd0, 32'h0, 3'b0, 1'b0, 1'b0, 32'h0);
    tbl[6]  = mk(9'b1_0_0_000_100, 32'h77, 32'h0, 32'h0, 32'h0, 5'd4, 3'd0, 32'h77, 3'b100, 1'b0, 1'b0, 32'h0);
    tbl[7]  = mk(9'b1_0_0_100_000, 32'h1, 32'h300, 32'h10, 32'h0, 5'd0, 3'd0, 32'h1, 3'b000, 1'b0, 1'b0, 32'h0);
    tbl[8]  = idle;
    tbl[9]  = mk(9'b1_0_1_001_100, 32'h203, 32'h40, 32'h0, 32'h0, 5'd1, 3'd0, 32'h44, 3'b000, 1'b1, 1'b0, 32'h0);
    tbl[10] = mk(9'b1_0_0_000_100, 32'h99, 32'h0, 32'h0, 32'h0, 5'd6, 3'd0, 32'h99, 3'b100, 1'b0, 1'b0, 32'h0);
    tbl[11] = mk(9'b1_0_1_010_100, 32'h0, 32'h80, 32'h10, 32'h0, 5'd1, 3'd0, 32'h84, 3'b100, 1'b0, 1'b1, 32'h90);
    tbl[12] = idle;
    tbl[13] = mk(9'b1_1_0_000_100, 32'h1, 32'h0, 32'h0, 32'h0, 5'd8, 3'd0, 32'h0, 3'b0, 1'b0, 1'b0, 32'h0);
    tbl[14] = idle;
    tbl[15] = mk(9'b1_1_0_000_100, 32'h2, 32'h0, 32'h0, 32'h0, 5'd8, 3'd0, 32'h0, 3'b0, 1'b0, 1'b0, 32'h0);
    tbl[16] = mk(9'b1_0_0_000_100, 32'hAB, 32'h0, 32'h0, 32'h0, 5'd9, 3'd0, 32'hAB, 3'b100, 1'b0, 1'b0, 32'h0);
    tbl[17] = mk(9'b1_0_1_100_000, 32'h0, 32'hFFFFFFF0, 32'h20, 32'h0, 5'd0, 3'd0, 32'h0, 3'b000, 1'b0, 1'b1, 32'h10);
    tbl[18] = mk(9'b1_1_0_000_100, 32'h3, 32'h0, 32'h0, 32'h0, 5'd2, 3'd0, 32'h0, 3'b0, 1'b0, 1'b0, 32'h0);
    tbl[19] = mk(9'b1_1_0_000_100, 32'h4, 32'h0, 32'h0, 32'h0, 5'd2, 3'd0, 32'h0, 3'b0, 1'b0, 1'b0, 32'h0);
    tbl[20] = mk(9'b1_0_0_000_100, 32'h12, 32'h0, 32'h0, 32'h0, 5'd10, 3'd0, 32'h12, 3'b100, 1'b0, 1'b0, 32'h0);
    tbl[21] = mk(9'b1_0_1_001_100, 32'h401, 32'h50, 32'h0, 32'h0, 5'd1, 3'd0, 32'h54, 3'b100, 1'b0, 1'b1, 32'h400);
    tbl[22] = mk(9'b1_1_0_000_001, 32'h5, 32'h0, 32'h0, 32'h0, 5'd0, 3'd0, 32'h0, 3'b0, 1'b0, 1'b0, 32'h0);
    tbl[23] = mk(9'b1_1_0_000_001, 32'h6, 32'h0, 32'h0, 32'h0, 5'd0, 3'd0, 32'h0, 3'b0, 1'b0, 1'b0, 32'h0);
    tbl[24] = mk(9'b1_0_0_000_001, 32'h44, 32'h0, 32'h0, 32'hCAFE, 5'd0, 3'd1, 32'h44, 3'b001, 1'b0, 1'b0, 32'h0);
    tbl[25] = idle;
    tbl[26] = mk(9'b1_0_1_100_000, 32'h0, 32'h100, 32'h6, 32'h0, 5'd0, 3'd0, 32'h0, 3'b000, 1'b1, 1'b0, 32'h0);
    tbl[27] = mk(9'b1_0_0_000_100, 32'h5, 32'h0, 32'h0, 32'h0, 5'd2, 3'd0, 32'h5, 3'b100, 1'b0, 1'b0, 32'h0);
    tbl[28] = idle;

    // Reset state
    rst = 1'b1;
    drive(idle, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst.alu_out", mem_alu_out, 32'd0);
    chk("rst.redirect", {30'd0, redirect_valid, misalign_exc}, 32'd0);
    chk("rst.redirect_pc", redirect_pc, 32'd0);
    rst = 1'b0;

    // Table: mem_ready held high so every valid vector is accepted
    for (int i = 0; i < 29; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(tbl[i], 1'b1);
      if (tbl[i].ctl[8] && !tbl[i].ctl[7]) sb.push_back(mkexp(tbl[i]));
      @(negedge clk);
      chk({tag, ".ex_ready"}, {31'd0, ex_ready}, 32'd1);
      @(posedge clk);
      #1;
      if (tbl[i].ctl[8] && !tbl[i].ctl[7]) check_mem(tag);
      else chk({tag, ".mem_valid"}, {31'd0, mem_valid}, 32'd0);
      chk({tag, ".redirect_valid"}, {31'd0, redirect_valid}, {31'd0, tbl[i].e_redir});
      if (tbl[i].e_redir) chk({tag, ".redirect_pc"}, redirect_pc, tbl[i].e_rpc);
      chk({tag, ".misalign"}, {31'd0, misalign_exc}, {31'd0, tbl[i].e_mis});
    end

    // Reset in the middle of a squash window
    drive(tbl[3], 1'b1);
    sb.push_back(mkexp(tbl[3]));
    @(posedge clk);
    #1;
    check_mem("rk.br");
    chk("rk.redirect_valid", {31'd0, redirect_valid}, 32'd1);
    drive(idle, 1'b1);
    rst = 1'b1;
    #1;
    chk("rk.async_clear", {29'd0, mem_valid, redirect_valid, misalign_exc}, 32'd0);
    chk("rk.alu_cleared", mem_alu_out, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    v = mk(9'b1_0_0_000_100, 32'h66, 32'h0, 32'h0, 32'h0, 5'd11, 3'd0, 32'h66, 3'b100, 1'b0, 1'b0, 32'h0);
    drive(v, 1'b1);
    sb.push_back(mkexp(v));
    @(posedge clk);
    #1;
    check_mem("rk.after");

    // Stall: JAL held in EX while MEM is blocked
    v = mk(9'b1_0_0_000_100, 32'h11, 32'h0, 32'h0, 32'h0, 5'd2, 3'd0, 32'h11, 3'b100, 1'b0, 1'b0, 32'h0);
    drive(v, 1'b1);
    sb.push_back(mkexp(v));
    @(posedge clk);
    #1;
    check_mem("st.fill");
    v = mk(9'b1_0_1_010_100, 32'h0, 32'h80, 32'h10, 32'h0, 5'd1, 3'd0, 32'h84, 3'b100, 1'b0, 1'b1, 32'h90);
    drive(v, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("st%0d.ex_ready", c), {31'd0, ex_ready}, 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("st%0d.mem_valid", c), {31'd0, mem_valid}, 32'd1);
      chk($sformatf("st%0d.alu_hold", c), mem_alu_out, 32'h11);
      chk($sformatf("st%0d.rd_hold", c), {27'd0, mem_rd}, 32'd2);
      chk($sformatf("st%0d.no_redirect", c), {31'd0, redirect_valid}, 32'd0);
    end
    mem_ready = 1'b1;
    sb.push_back(mkexp(v));
    @(negedge clk);
    chk("st.release_ready", {31'd0, ex_ready}, 32'd1);
    @(posedge clk);
    #1;
    check_mem("st.jal");
    chk("st.redirect_valid", {31'd0, redirect_valid}, 32'd1);
    chk("st.redirect_pc", redirect_pc, 32'h90);
    drive(idle, 1'b1);
    @(posedge clk);
    #1;
    chk("st.drain", {31'd0, mem_valid}, 32'd0);
    chk("st.pulse_end", {31'd0, redirect_valid}, 32'd0);
    chk("sb.leftover", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
